// File: rtl/dp_arbiter.sv
// Two-channel arbiter for a shared FIR datapath register file.
// It grants locked bursts round-robin, or with fixed ch0 priority when ARB_FIXED_PRIO_EN is defined.
module dp_arbiter #(
  parameter int         MAX_HOLD = 16,
  parameter logic [2:0] OP_NOP   = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic       lock0,
  input  logic       lock1,
  input  logic [2:0] op0,
  input  logic [2:0] op1,
  input  logic [2:0] src1_0,
  input  logic [2:0] src1_1,
  input  logic [2:0] src2_0,
  input  logic [2:0] src2_1,
  input  logic [2:0] dest0,
  input  logic [2:0] dest1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       ovf0,
  output logic       ovf1,
  output logic [2:0] dp_op,
  output logic [3:0] dp_src1,
  output logic [3:0] dp_src2,
  output logic [3:0] dp_dest,
  input  logic       dp_overflow,
  output logic       busy,
  output logic       err,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam int            HW        = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  state_t          state_q, state_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic            err_q, err_d;
  logic            own_idx, own_lock, oth_req;
  logic            issue0, issue1;
`ifndef ARB_FIXED_PRIO_EN
  logic            last_q, last_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      err_q      <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      last_q     <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      err_q      <= err_d;
`ifndef ARB_FIXED_PRIO_EN
      last_q     <= last_d;
`endif
    end
  end

  assign own_idx  = (state_q == OWN1);
  assign own_lock = own_idx ? lock1 : lock0;
  assign oth_req  = own_idx ? req0 : req1;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    err_d      = 1'b0;
`ifndef ARB_FIXED_PRIO_EN
    last_d     = last_q;
`endif
    case (state_q)
      IDLE: begin
        hold_cnt_d = '0;
        if (req0 && req1) begin
`ifdef ARB_FIXED_PRIO_EN
          state_d = OWN0;
`else
          state_d = last_q ? OWN0 : OWN1;
`endif
        end else if (req0) begin
          state_d = OWN0;
        end else if (req1) begin
          state_d = OWN1;
        end
      end
      OWN0, OWN1: begin
        // Release on a final command (or idle unlock); otherwise force it at the hold limit.
        if (!own_lock || hold_cnt_q == HOLD_LAST) begin
          err_d      = own_lock;
          hold_cnt_d = '0;
`ifndef ARB_FIXED_PRIO_EN
          last_d     = own_idx;
`endif
          if (oth_req) state_d = own_idx ? OWN0 : OWN1;
          else         state_d = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt0      = (state_q == OWN0);
  assign gnt1      = (state_q == OWN1);
  assign busy      = (state_q != IDLE);
  assign err       = err_q;
  assign dbg_state = state_q;
  assign issue0    = gnt0 & req0;
  assign issue1    = gnt1 & req1;
  assign ovf0      = dp_overflow & issue0;
  assign ovf1      = dp_overflow & issue1;

  // Each channel sees its own 8 registers; the owner index selects the file half.
  always_comb begin
    dp_op   = OP_NOP;
    dp_src1 = 4'd0;
    dp_src2 = 4'd0;
    dp_dest = 4'd0;
    if (issue0) begin
      dp_op   = op0;
      dp_src1 = {1'b0, src1_0};
      dp_src2 = {1'b0, src2_0};
      dp_dest = {1'b0, dest0};
    end else if (issue1) begin
      dp_op   = op1;
      dp_src1 = {1'b1, src1_1};
      dp_src2 = {1'b1, src2_1};
      dp_dest = {1'b1, dest1};
    end
  end

endmodule
